// File: rtl/matrix_input_assembler_pkg.sv
// Shared constants, FSM state encoding and error codes for the matrix input assembler.
package matrix_pkg;

  localparam int MAX_DIM    = 5;
  localparam int MAX_ELEM   = 25;
  localparam int ELEM_WIDTH = 8;
  localparam int MAT_BUS_W  = MAX_ELEM * ELEM_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_Y    = 2'd1,
    GET_ELEM = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DIM     = 2'd1;
  localparam logic [1:0] ERR_VAL     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic logic dim_ok(input logic [7:0] d);
    return (d != 8'd0) && (d <= 8'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matrix_input_assembler_if.sv
// Byte-stream input handshake plus store-write and status outputs of the assembler.
interface matrix_input_assembler_if;
  import matrix_pkg::*;

  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 abort;
  logic                 wr_en;
  logic [7:0]           dim_x;
  logic [7:0]           dim_y;
  logic [MAT_BUS_W-1:0] wr_data;
  logic                 busy;
  logic                 err;
  logic [1:0]           err_code;

  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, wr_en, dim_x, dim_y, wr_data, busy, err, err_code
  );

  modport master (
    output in_valid, in_data, abort,
    input  in_ready, wr_en, dim_x, dim_y, wr_data, busy, err, err_code
  );

endinterface

// File: rtl/matrix_input_timeout.sv
// Inter-byte watchdog: down-counter reloaded on clear or when disabled, expires at terminal count.
module matrix_input_timeout #(
  parameter int unsigned LIMIT = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [31:0] cnt;

  // A clear in the terminal cycle wins, so a late byte is never flagged.
  assign expire = (LIMIT != 0) && en && !clr && (cnt == 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr) begin
      cnt <= LIMIT;
    end else if (cnt != 32'd0) begin
      cnt <= cnt - 32'd1;
    end
  end

endmodule

// File: rtl/matrix_input_assembler.sv
// Parses a dimX/dimY header and dimX*dimY row-major bytes, then strobes one packed matrix to the store.
//   state    | meaning
//   IDLE     | waiting for dimX byte
//   GET_Y    | waiting for dimY byte
//   GET_ELEM | collecting elements into the working buffer
//   COMMIT   | wr_en high, input stalled for one cycle
module matrix_input_assembler
  import matrix_pkg::*;
#(
  parameter int unsigned MAX_VAL     = 255,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  matrix_input_assembler_if.slave   bus
);

  state_t               state;
  logic [7:0]           dx_q;
  logic [7:0]           dy_q;
  logic [4:0]           cnt_q;
  logic [4:0]           total_q;
  logic [MAT_BUS_W-1:0] elem_buf;
  logic [MAT_BUS_W-1:0] next_buf;
  logic [4:0]           total_w;
  logic                 fire;
  logic                 val_bad;
  logic                 tmo_en;
  logic                 expire;

  logic                 wr_en_q;
  logic [7:0]           dim_x_q;
  logic [7:0]           dim_y_q;
  logic [MAT_BUS_W-1:0] wr_data_q;
  logic                 err_q;
  logic [1:0]           err_code_q;

  assign fire    = bus.in_valid & bus.in_ready;
  assign val_bad = {24'd0, bus.in_data} > MAX_VAL;
  assign total_w = {2'b00, dx_q[2:0]} * {2'b00, bus.in_data[2:0]};
  assign tmo_en  = (state == GET_Y) || (state == GET_ELEM);

  always_comb begin
    next_buf = elem_buf;
    next_buf[cnt_q*ELEM_WIDTH +: ELEM_WIDTH] = bus.in_data;
  end

  matrix_input_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (tmo_en),
    .clr    (fire | bus.abort),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dx_q       <= '0;
      dy_q       <= '0;
      cnt_q      <= '0;
      total_q    <= '0;
      elem_buf   <= '0;
      wr_en_q    <= 1'b0;
      dim_x_q    <= '0;
      dim_y_q    <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            dx_q     <= bus.in_data;
            elem_buf <= '0;
            state    <= GET_Y;
          end
        end
        GET_Y: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (fire) begin
            dy_q <= bus.in_data;
            if (!dim_ok(dx_q) || !dim_ok(bus.in_data)) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_DIM;
              state      <= IDLE;
            end else begin
              cnt_q   <= '0;
              total_q <= total_w;
              state   <= GET_ELEM;
            end
          end else if (expire) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state      <= IDLE;
          end
        end
        GET_ELEM: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (fire) begin
            if (val_bad) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_VAL;
              state      <= IDLE;
            end else begin
              elem_buf <= next_buf;
              cnt_q    <= cnt_q + 5'd1;
              // Outputs load on the last fire so wr_en is visible during COMMIT.
              if (cnt_q == total_q - 5'd1) begin
                wr_en_q   <= 1'b1;
                dim_x_q   <= dx_q;
                dim_y_q   <= dy_q;
                wr_data_q <= next_buf;
                state     <= COMMIT;
              end
            end
          end else if (expire) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state      <= IDLE;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state != COMMIT);
  assign bus.busy     = (state != IDLE);
  assign bus.wr_en    = wr_en_q;
  assign bus.dim_x    = dim_x_q;
  assign bus.dim_y    = dim_y_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: doc/matrix_input_assembler.md
Name: matrix_input_assembler

Overview:
- Upstream stage of the matrix store. Receives a byte stream over a valid/ready handshake from the UART or switch front end.
- Parses a two-byte dimension header, collects dimX*dimY elements in row-major order and packs them into one 25-element, zero-padded bus.
- Issues a single-cycle write strobe with dims and data that drive the store's writeEnable/dimX/dimY/writeData directly.
- Flags malformed, out-of-range and stalled transfers.

Parameters:
- MAX_DIM, 5, largest legal row/column count
- MAX_ELEM, 25, element slots on the output bus (MAX_DIM*MAX_DIM)
- ELEM_WIDTH, 8, bits per element
- MAX_VAL, 255, largest legal element value; larger values are errors
- TIMEOUT_CYC, 50000000, idle cycles allowed between bytes inside a matrix (0 disables)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte (header or element)
- in_ready  out  1  assembler can accept in_data this cycle
- abort  in  1  synchronous pulse, drop current matrix
- wr_en  out  1  one-cycle strobe to the store
- dim_x  out  8  column count of committed matrix
- dim_y  out  8  row count of committed matrix
- wr_data  out  MAX_ELEM*ELEM_WIDTH  packed elements; element k at bits [k*8 +: 8]
- busy  out  1  high outside IDLE
- err  out  1  one-cycle error strobe
- err_code  out  2  1=bad dim, 2=element>MAX_VAL, 3=timeout; holds until next err

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low. All state is reset on assertion regardless of clk.
- Reset values: state=IDLE, in_ready=1, wr_en=0, err=0, err_code=0, busy=0, dim_x=0, dim_y=0, wr_data=0, element counter=0, timeout counter=0.
- Handshake: fire = in_valid & in_ready. in_data is sampled only on fire. in_ready=1 in IDLE, GET_Y and GET_ELEM; in_ready=0 in COMMIT.
- IDLE: on fire, latch in_data as dimX into the working register, clear the working buffer to 0, go to GET_Y. busy rises the next cycle.
- GET_Y:
  - On fire, latch dimY.
  - If dimX or dimY lies outside 1..MAX_DIM: err=1, err_code=1 next cycle, return to IDLE. No resync; following bytes are parsed as a new header.
  - Otherwise go to GET_ELEM with count=0 and total=dimX*dimY (5-bit result).
- GET_ELEM:
  - On fire with in_data<=MAX_VAL: store at buffer index count (row-major, index=row*dimX+col), count++.
  - On the fire where count==total-1 (last element), go to COMMIT.
  - On fire with in_data>MAX_VAL: err_code=2, drop the matrix, go to IDLE.
- COMMIT (one cycle): register the outputs.
  - wr_en=1 in the cycle following acceptance of the last element.
  - dim_x, dim_y and wr_data update in the same cycle as wr_en.
  - Next state is IDLE; wr_en is low again the cycle after.
  - Slots >= total are 0.
- Output hold: dim_x, dim_y and wr_data hold their values after commit until the next commit. Errors never alter them.
- Timeout:
  - The counter runs in GET_Y and GET_ELEM and clears on every fire.
  - When it reaches TIMEOUT_CYC with no fire: err_code=3, go to IDLE.
  - Counter width is 32 bits.
- abort:
  - In any non-IDLE state: go to IDLE, no err, no wr_en.
  - abort takes priority over a simultaneous fire; that byte is consumed and discarded.
  - In IDLE, abort is ignored.
- Simultaneous events: the timeout limit and a fire in the same cycle count as a fire. Error priority: abort > range/dim check > timeout.
- Reset mid-matrix: the partial matrix is lost and no wr_en is issued.
- Throughput: 1 byte per cycle. A 1x1 matrix takes 3 fires plus 1 commit cycle, so back-to-back matrices need total+3 cycles each.

Decomposition:
- Shared package matrix_pkg:
  - MAX_DIM, MAX_ELEM, ELEM_WIDTH
  - state enum {IDLE, GET_Y, GET_ELEM, COMMIT}
  - err code constants ERR_NONE/ERR_DIM/ERR_VAL/ERR_TIMEOUT
  - bus width constant MAT_BUS_W=MAX_ELEM*ELEM_WIDTH
- One natural sub-module: matrix_input_timeout, a loadable watchdog counter with clear/enable/expire. All else inline.

Test Plan:
- Header 2,3 then bytes 1..6, in_valid held high -> wr_en high exactly one cycle, 1 cycle after the byte-6 fire. dim_x=2, dim_y=3, wr_data[47:0]=06_05_04_03_02_01, bits above 47 all 0.
- Header 6,1 -> err pulse with err_code=1 after the second byte. Return to IDLE, no wr_en, previous dim_x/wr_data unchanged.
- MAX_VAL=9, header 2,2, elements 3,12 -> err_code=2 after the 12. A following valid 1,1,7 commits dim 1x1 with wr_data[7:0]=7.
- TIMEOUT_CYC=10, header 3,3, 4 elements, then in_valid low for 10 cycles -> err_code=3. busy falls, no wr_en.
- Header 5,5 plus 25 elements with in_valid toggling randomly -> in_ready low only in the COMMIT cycle. wr_data holds 25 bytes in order; exactly 1 wr_en.
- rst_n low asynchronously mid-GET_ELEM, and abort during GET_ELEM -> all outputs return to reset values (reset case), or IDLE with no err (abort case). The next full 1x1 matrix commits correctly.
